// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared bus types, access-size codes and FSM state encoding for the ysyx_23060332 LSU.
// Optional misaligned-access trapping is enabled by defining YSYX_23060332_LSU_MISALIGN_EN.
package ysyx_23060332_lsu_pkg;

    typedef logic [31:0] mem_addr_bus_t;
    typedef logic [31:0] mem_data_bus_t;

    localparam mem_data_bus_t ZeroWord = 32'h0000_0000;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    // Size code 2'b11 behaves as a word, so it shares the word alignment rule.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = offset[0];
            LSU_SIZE_W: bad = (offset != 2'b00);
            default:    bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational byte-lane logic: store data replication and mask, load extraction and extension.
// Half accesses look only at offset[1]; word accesses ignore the offset entirely.
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic [1:0]    offset,
    input  logic [1:0]    size,
    input  logic          zero_ext,
    input  mem_data_bus_t store_data,
    input  mem_data_bus_t load_word,
    output mem_data_bus_t lane_data,
    output logic [3:0]    lane_mask,
    output mem_data_bus_t load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = load_word[{offset, 3'b000} +: 8];
    assign load_half = load_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        lane_data = store_data;
        lane_mask = 4'b1111;
        load_data = load_word;
        case (size)
            LSU_SIZE_B: begin
                lane_data = {4{store_data[7:0]}};
                lane_mask = 4'b0001 << offset;
                load_data = zero_ext ? {24'h000000, load_byte}
                                     : {{24{load_byte[7]}}, load_byte};
            end
            LSU_SIZE_H: begin
                lane_data = {2{store_data[15:0]}};
                lane_mask = 4'b0011 << {offset[1], 1'b0};
                load_data = zero_ext ? {16'h0000, load_half}
                                     : {{16{load_half[15]}}, load_half};
            end
            default: begin
                lane_data = store_data;
                lane_mask = 4'b1111;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit between EXU and physical memory: request latch, latency countdown, single
// memory strobe per access, and a held WBU result. Define YSYX_23060332_LSU_MISALIGN_EN to trap misaligned accesses.
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int LAT = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        lsu_ready,
    input  logic [31:0] exu_addr,
    input  logic [31:0] exu_wdata,
    input  logic        exu_ren,
    input  logic        exu_wen,
    input  logic [1:0]  exu_size,
    input  logic        exu_unsigned,
    input  logic [4:0]  exu_rd,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        wbu_valid,
    input  logic        wbu_ready,
    output logic [31:0] wbu_rdata,
    output logic [4:0]  wbu_rd,
    output logic        wbu_wen,
    output logic        lsu_err
);

    lsu_state_e    state;
    logic [3:0]    cnt;
    mem_addr_bus_t addr_q;
    mem_data_bus_t wdata_q;
    mem_data_bus_t result_q;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic [4:0]    rd_q;
    logic          load_q;
    logic          store_q;
    logic          wen_q;
    logic          access_now;
    mem_data_bus_t lane_data;
    logic [3:0]    lane_mask;
    mem_data_bus_t load_data;

    ysyx_23060332_lsu_align u_align (
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .zero_ext   (unsigned_q),
        .store_data (wdata_q),
        .load_word  (mem_rdata),
        .lane_data  (lane_data),
        .lane_mask  (lane_mask),
        .load_data  (load_data)
    );

    assign access_now = (state == LSU_ACCESS) && (cnt == 4'd0);

    // Strobes and wbu_valid are gated by rst so a reset landing on the strobe cycle commits nothing.
    assign mem_ren   = !rst && access_now && load_q;
    assign mem_wen   = !rst && access_now && store_q;
    assign mem_raddr = {addr_q[31:2], 2'b00};
    assign mem_waddr = {addr_q[31:2], 2'b00};
    assign mem_wdata = lane_data;
    assign mem_wmask = mem_wen ? {4'h0, lane_mask} : 8'h00;

    assign lsu_ready = (state == LSU_IDLE);
    assign wbu_valid = !rst && (state == LSU_RESP);
    assign wbu_rdata = result_q;
    assign wbu_rd    = rd_q;
    assign wbu_wen   = wen_q;

`ifdef YSYX_23060332_LSU_MISALIGN_EN
    logic err_q;
    assign lsu_err = err_q;
`else
    assign lsu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LSU_IDLE;
            cnt        <= 4'd0;
            addr_q     <= ZeroWord;
            wdata_q    <= ZeroWord;
            result_q   <= ZeroWord;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            rd_q       <= 5'd0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            wen_q      <= 1'b0;
`ifdef YSYX_23060332_LSU_MISALIGN_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (exu_valid) begin
                        addr_q     <= exu_addr;
                        wdata_q    <= exu_wdata;
                        size_q     <= exu_size;
                        unsigned_q <= exu_unsigned;
                        rd_q       <= exu_rd;
                        // A request flagged as both load and store is served as a plain load.
                        load_q     <= exu_ren;
                        store_q    <= exu_wen && !exu_ren;
                        result_q   <= ZeroWord;
                        wen_q      <= 1'b0;
                        cnt        <= 4'(LAT);
`ifdef YSYX_23060332_LSU_MISALIGN_EN
                        err_q      <= 1'b0;
`endif
                        if (!(exu_ren || exu_wen)) begin
                            state <= LSU_RESP;
                        end
`ifdef YSYX_23060332_LSU_MISALIGN_EN
                        else if (lsu_misaligned(exu_size, exu_addr[1:0])) begin
                            state <= LSU_RESP;
                            err_q <= 1'b1;
                        end
`endif
                        else begin
                            state <= LSU_ACCESS;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (load_q) begin
                            result_q <= load_data;
                            wen_q    <= (rd_q != 5'd0);
                        end
                        state <= LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    if (wbu_ready) begin
                        state <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for ysyx_23060332_lsu: an LAT=0 instance for datapath/handshake cases and an
// LAT=3 instance for back-pressure timing; honours YSYX_23060332_LSU_MISALIGN_EN when defined.
module tb_ysyx_23060332_lsu;

`ifdef YSYX_23060332_LSU_MISALIGN_EN
    localparam bit MISALIGN = 1'b1;
`else
    localparam bit MISALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        exu_valid = 1'b0, exu_ren = 1'b0, exu_wen = 1'b0, exu_unsigned = 1'b0;
    logic [31:0] exu_addr = 32'h0, exu_wdata = 32'h0;
    logic [1:0]  exu_size = 2'b00;
    logic [4:0]  exu_rd = 5'd0;
    logic        wbu_ready = 1'b1;
    logic        lsu_ready, mem_ren, mem_wen, wbu_valid, wbu_wen, lsu_err;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata, wbu_rdata;
    logic [7:0]  mem_wmask;
    logic [4:0]  wbu_rd;

    logic        exu_valid3 = 1'b0, exu_ren3 = 1'b0, exu_wen3 = 1'b0, exu_unsigned3 = 1'b0;
    logic [31:0] exu_addr3 = 32'h0, exu_wdata3 = 32'h0;
    logic [1:0]  exu_size3 = 2'b00;
    logic [4:0]  exu_rd3 = 5'd0;
    logic        wbu_ready3 = 1'b1;
    logic        lsu_ready3, mem_ren3, mem_wen3, wbu_valid3, wbu_wen3, lsu_err3;
    logic [31:0] mem_raddr3, mem_rdata3, mem_waddr3, mem_wdata3, wbu_rdata3;
    logic [7:0]  mem_wmask3;
    logic [4:0]  wbu_rd3;

    ysyx_23060332_lsu #(.LAT(0)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_ren(exu_ren), .exu_wen(exu_wen),
        .exu_size(exu_size), .exu_unsigned(exu_unsigned), .exu_rd(exu_rd),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .wbu_valid(wbu_valid), .wbu_ready(wbu_ready), .wbu_rdata(wbu_rdata),
        .wbu_rd(wbu_rd), .wbu_wen(wbu_wen), .lsu_err(lsu_err)
    );

    ysyx_23060332_lsu #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst), .exu_valid(exu_valid3), .lsu_ready(lsu_ready3),
        .exu_addr(exu_addr3), .exu_wdata(exu_wdata3), .exu_ren(exu_ren3), .exu_wen(exu_wen3),
        .exu_size(exu_size3), .exu_unsigned(exu_unsigned3), .exu_rd(exu_rd3),
        .mem_ren(mem_ren3), .mem_raddr(mem_raddr3), .mem_rdata(mem_rdata3),
        .mem_wen(mem_wen3), .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3),
        .wbu_valid(wbu_valid3), .wbu_ready(wbu_ready3), .wbu_rdata(wbu_rdata3),
        .wbu_rd(wbu_rd3), .wbu_wen(wbu_wen3), .lsu_err(lsu_err3)
    );

    // Word-addressed memories covering 0x80000000..0x800000FF; anything else reads as 0.
    logic [31:0] mem0 [0:63];
    logic [31:0] mem3 [0:63];

    assign mem_rdata  = (mem_ren && mem_raddr[31:8] == 24'h800000) ? mem0[mem_raddr[7:2]] : 32'h0;
    assign mem_rdata3 = (mem_ren3 && mem_raddr3[31:8] == 24'h800000) ? mem3[mem_raddr3[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_wen && mem_waddr[31:8] == 24'h800000)
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem0[mem_waddr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_wen3 && mem_waddr3[31:8] == 24'h800000)
            for (int j = 0; j < 4; j++)
                if (mem_wmask3[j]) mem3[mem_waddr3[7:2]][8*j +: 8] <= mem_wdata3[8*j +: 8];
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
    } resp_t;

    typedef struct {
        string       tag;
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  mask;
    } strobe_t;

    resp_t   resp_q[$];
    strobe_t strobe_q[$];
    resp_t   mon_r;
    strobe_t mon_s;

    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Drives one request into the LAT=0 unit and queues the strobe and response it must produce.
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic ren, input logic wen, input logic [1:0] size,
                                 input logic uns, input logic [4:0] rd, input logic strobe,
                                 input logic [7:0] mask, input logic [31:0] lanes,
                                 input logic [31:0] exp_rdata, input logic exp_wen, input logic exp_err);
        int lat;
        resp_t   r;
        strobe_t s;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 64'(lsu_ready), 64'd1);
        exu_addr = addr; exu_wdata = wdata; exu_ren = ren; exu_wen = wen;
        exu_size = size; exu_unsigned = uns; exu_rd = rd; exu_valid = 1'b1;
        if (strobe) begin
            s.tag = tag; s.write = wen && !ren; s.addr = {addr[31:2], 2'b00};
            s.data = lanes; s.mask = mask;
            strobe_q.push_back(s);
        end
        r.tag = tag; r.rdata = exp_rdata; r.rd = rd; r.wen = exp_wen; r.err = exp_err;
        resp_q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        exu_valid = 1'b0;
        lat = 1;
        while (!wbu_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), strobe ? 64'd2 : 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_ren || mem_wen) begin
                checkOutput("strobe_exclusive", 64'(mem_ren && mem_wen), 64'd0);
                checkOutput("strobe_expected", 64'(strobe_q.size() != 0), 64'd1);
                if (strobe_q.size() != 0) begin
                    mon_s = strobe_q.pop_front();
                    checkOutput({mon_s.tag, "_kind"}, 64'(mem_wen), 64'(mon_s.write));
                    if (mon_s.write) begin
                        checkOutput({mon_s.tag, "_waddr"}, 64'(mem_waddr), 64'(mon_s.addr));
                        checkOutput({mon_s.tag, "_lanes"}, {24'h0, mem_wdata, mem_wmask},
                                    {24'h0, mon_s.data, mon_s.mask});
                    end else begin
                        checkOutput({mon_s.tag, "_raddr"}, 64'(mem_raddr), 64'(mon_s.addr));
                    end
                end
            end
            if (wbu_valid && wbu_ready) begin
                checkOutput("resp_expected", 64'(resp_q.size() != 0), 64'd1);
                if (resp_q.size() != 0) begin
                    mon_r = resp_q.pop_front();
                    checkOutput({mon_r.tag, "_rdata"}, 64'(wbu_rdata), 64'(mon_r.rdata));
                    checkOutput({mon_r.tag, "_ctl"}, 64'({wbu_rd, wbu_wen, lsu_err}),
                                64'({mon_r.rd, mon_r.wen, mon_r.err}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int ren_at;
        int ren_cnt;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ctl", 64'({lsu_ready, wbu_valid, mem_ren, mem_wen, wbu_wen, lsu_err, mem_wmask, wbu_rd}),
                    64'({1'b1, 5'b00000, 8'h00, 5'd0}));
        checkOutput("reset_addr", {mem_raddr, mem_waddr}, 64'd0);
        checkOutput("reset_data", {mem_wdata, wbu_rdata}, 64'd0);
        checkOutput("reset3_ctl", 64'({lsu_ready3, wbu_valid3, mem_ren3, mem_wen3, wbu_wen3, lsu_err3}),
                    64'({1'b1, 5'b00000}));

        //            tag               addr          wdata         ren   wen   size   uns   rd    stb   mask   lanes         exp_rdata     wen   err
        applyStimulus("sw_deadbeef",   32'h80000010, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b1, 8'h0F, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lw_deadbeef",   32'h80000010, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1, 8'h00, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus("sb_a5",         32'h80000013, 32'h123456A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 1'b1, 8'h08, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lb_a5",         32'h80000013, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b0, 5'd6, 1'b1, 8'h00, 32'h0,        32'hFFFFFFA5, 1'b1, 1'b0);
        applyStimulus("lbu_a5",        32'h80000013, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 8'h00, 32'h0,        32'h000000A5, 1'b1, 1'b0);
        applyStimulus("lbu_ef",        32'h80000010, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 8'h00, 32'h0,        32'h000000EF, 1'b1, 1'b0);
        applyStimulus("lb_be",         32'h80000011, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b0, 5'd6, 1'b1, 8'h00, 32'h0,        32'hFFFFFFBE, 1'b1, 1'b0);
        applyStimulus("sw_80017f00",   32'h80000010, 32'h80017F00, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b1, 8'h0F, 32'h80017F00, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lh_8001",       32'h80000012, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 1'b1, 8'h00, 32'h0,        32'hFFFF8001, 1'b1, 1'b0);
        applyStimulus("lhu_8001",      32'h80000012, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b1, 5'd7, 1'b1, 8'h00, 32'h0,        32'h00008001, 1'b1, 1'b0);
        applyStimulus("lh_7f00",       32'h80000010, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 1'b1, 8'h00, 32'h0,        32'h00007F00, 1'b1, 1'b0);
        applyStimulus("sw_11223344",   32'h80000014, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b1, 8'h0F, 32'h11223344, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("sh_beef",       32'h80000016, 32'hCAFEBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 8'h0C, 32'hBEEFBEEF, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lw_rd0",        32'h80000014, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd0, 1'b1, 8'h00, 32'h0,        32'hBEEF3344, 1'b0, 1'b0);
        applyStimulus("nop",           32'h80000014, 32'h00000000, 1'b0, 1'b0, 2'b10, 1'b0, 5'd3, 1'b0, 8'h00, 32'h0,        32'h00000000, 1'b0, 1'b0);
        applyStimulus("rw_both",       32'h80000010, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b10, 1'b0, 5'd8, 1'b1, 8'h00, 32'h0,        32'h80017F00, 1'b1, 1'b0);
        applyStimulus("lw_after_both", 32'h80000010, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 1'b1, 8'h00, 32'h0,        32'h80017F00, 1'b1, 1'b0);
        applyStimulus("lw_oob",        32'h00000100, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1, 8'h00, 32'h0,        32'h00000000, 1'b1, 1'b0);
        applyStimulus("sw_cafef00d",   32'h80000000, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b1, 8'h0F, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lw_misalign",   32'h80000002, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd10, !MISALIGN, 8'h00, 32'h0,
                      MISALIGN ? 32'h00000000 : 32'hCAFEF00D, !MISALIGN, MISALIGN);
        applyStimulus("lh_odd",        32'h80000011, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 5'd11, !MISALIGN, 8'h00, 32'h0,
                      MISALIGN ? 32'h00000000 : 32'h00007F00, !MISALIGN, MISALIGN);
        applyStimulus("lw_size3",      32'h80000010, 32'h00000000, 1'b1, 1'b0, 2'b11, 1'b0, 5'd12, 1'b1, 8'h00, 32'h0,       32'h80017F00, 1'b1, 1'b0);
        applyStimulus("sb_77",         32'h80000001, 32'h00000077, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 1'b1, 8'h02, 32'h77777777, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("lw_cafe770d",   32'h80000000, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd13, 1'b1, 8'h00, 32'h0,       32'hCAFE770D, 1'b1, 1'b0);

        // Reset lands exactly on the store's strobe cycle; the word at 0x80000014 must survive.
        @(negedge clk);
        checkOutput("rst_store_ready", 64'(lsu_ready), 64'd1);
        exu_addr = 32'h80000014; exu_wdata = 32'h55555555; exu_ren = 1'b0; exu_wen = 1'b1;
        exu_size = 2'b10; exu_unsigned = 1'b0; exu_rd = 5'd0; exu_valid = 1'b1;
        @(posedge clk);
        #1 exu_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_gate", 64'({mem_ren, mem_wen, wbu_valid}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ctl", 64'({lsu_ready, wbu_valid, mem_ren, mem_wen, wbu_wen, lsu_err, mem_wmask, wbu_rd}),
                    64'({1'b1, 5'b00000, 8'h00, 5'd0}));
        checkOutput("rst_mid_addr", {mem_raddr, mem_waddr}, 64'd0);
        checkOutput("rst_mid_data", {mem_wdata, wbu_rdata}, 64'd0);
        checkOutput("rst_mem_kept", 64'(mem0[5]), 64'h00000000BEEF3344);
        applyStimulus("lw_after_rst",  32'h80000014, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 5'd14, 1'b1, 8'h00, 32'h0,       32'hBEEF3344, 1'b1, 1'b0);

        // LAT=3 unit: preload a word, then load it while WBU stalls for five cycles.
        @(negedge clk);
        exu_addr3 = 32'h80000020; exu_wdata3 = 32'h12345678; exu_ren3 = 1'b0; exu_wen3 = 1'b1;
        exu_size3 = 2'b10; exu_unsigned3 = 1'b0; exu_rd3 = 5'd0; exu_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exu_valid3 = 1'b0;
        lat = 1;
        while (!wbu_valid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("lat3_store_latency", 64'(lat), 64'd5);
        @(negedge clk);
        wbu_ready3 = 1'b0;
        checkOutput("lat3_load_ready", 64'(lsu_ready3), 64'd1);
        exu_addr3 = 32'h80000020; exu_wdata3 = 32'h0; exu_ren3 = 1'b1; exu_wen3 = 1'b0;
        exu_size3 = 2'b10; exu_rd3 = 5'd9; exu_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // A competing store stays offered throughout and must be ignored.
        exu_ren3 = 1'b0; exu_wen3 = 1'b1; exu_wdata3 = 32'hFFFFFFFF;
        lat = 1; ren_at = 0; ren_cnt = 0;
        while (!wbu_valid3 && lat < 20) begin
            if (mem_ren3) begin ren_at = lat; ren_cnt++; end
            @(negedge clk);
            lat++;
        end
        checkOutput("lat3_latency", 64'(lat), 64'd5);
        checkOutput("lat3_ren_cycle", 64'(ren_at), 64'd4);
        checkOutput("lat3_ren_count", 64'(ren_cnt), 64'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("lat3_hold%0d", k),
                        64'({wbu_valid3, lsu_ready3, mem_ren3, mem_wen3, wbu_wen3, lsu_err3, wbu_rd3, wbu_rdata3}),
                        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h12345678}));
            @(negedge clk);
        end
        wbu_ready3 = 1'b1;
        exu_valid3 = 1'b0;
        @(negedge clk);
        checkOutput("lat3_release", 64'({lsu_ready3, wbu_valid3}), 64'({1'b1, 1'b0}));
        checkOutput("lat3_mem_kept", 64'(mem3[8]), 64'h0000000012345678);

        checkOutput("strobe_queue_empty", 64'(strobe_q.size()), 64'd0);
        checkOutput("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
